// File: rtl/matrix_scalar_mul_stream.sv
// matrix_scalar_mul_stream: streaming multi-lane fixed-point C = A * s with round, shift, saturate and end-of-matrix framing
module matrix_scalar_mul_stream #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int LANES  = 4,
  parameter int ROWS   = 4,
  parameter int COLS   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    scalar_we,
  input  logic [DATA_W-1:0]       scalar_in,
  output logic                    scalar_busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    out_last,
  output logic                    out_sat
);
  localparam int BEATS = ROWS * COLS / LANES;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int PW = 2 * DATA_W;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic signed [PW:0] RND = (PW+1)'(2 ** FRAC_W / 2);
  localparam logic signed [PW:0] MAXV = {{(DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW:0] MINV = ~MAXV;
  localparam logic [DATA_W-1:0] MAXO = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MINO = ~MAXO;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] scalar_q, scalar_d;
  logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic signed [PW-1:0] prod_q [LANES];
  logic signed [PW-1:0] prod_d [LANES];
  logic signed [PW-1:0] ax [LANES];
  logic signed [PW-1:0] sx;
  logic signed [PW:0] rnd [LANES];
  logic signed [PW:0] shf [LANES];
  logic [LANES-1:0] hi, lo;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d, out_sat_q, out_sat_d;
  logic [LANES*DATA_W-1:0] out_data_q, out_data_d;
  logic advance, wr_ok, acc, at_last, upd;
  always_comb begin
    advance     = !(out_valid_q && !out_ready);
    wr_ok       = scalar_we && cnt_q == '0;
    in_ready    = advance && !wr_ok;
    acc         = in_valid && in_ready;
    at_last     = cnt_q == LAST;
    upd         = advance && s1_valid_q;
    cnt_d       = acc ? (at_last ? '0 : cnt_q + CW'(1)) : cnt_q;
    scalar_d    = wr_ok ? scalar_in : scalar_q;
    s1_valid_d  = advance ? acc : s1_valid_q;
    s1_last_d   = acc ? at_last : s1_last_q;
    out_valid_d = advance ? s1_valid_q : out_valid_q;
    out_last_d  = upd ? s1_last_q : out_last_q;
    sx          = PW'($signed(scalar_q));
    out_data_d  = out_data_q;
    for (int i = 0; i < LANES; i++) begin
      ax[i]     = PW'($signed(in_data[i*DATA_W +: DATA_W]));
      prod_d[i] = acc ? ax[i] * sx : prod_q[i];
      rnd[i]    = {prod_q[i][PW-1], prod_q[i]} + RND;
      shf[i]    = rnd[i] >>> FRAC_W;
      hi[i]     = shf[i] > MAXV;
      lo[i]     = shf[i] < MINV;
      out_data_d[i*DATA_W +: DATA_W] = !upd ? out_data_q[i*DATA_W +: DATA_W] :
                                       hi[i] ? MAXO : lo[i] ? MINO : shf[i][DATA_W-1:0];
    end
    out_sat_d = upd ? |(hi | lo) : out_sat_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      scalar_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_sat_q   <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else begin
      cnt_q       <= cnt_d;
      scalar_q    <= scalar_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_sat_q   <= out_sat_d;
      out_data_q  <= out_data_d;
      for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
    end
  end
  assign scalar_busy = cnt_q != '0;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign out_sat     = out_sat_q;
endmodule

// File: tb/tb_matrix_scalar_mul_stream.sv
// tb_matrix_scalar_mul_stream: directed table-driven and sequence checks of matrix_scalar_mul_stream
module tb_matrix_scalar_mul_stream;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, scalar_we = 1'b0, out_ready = 1'b1;
  logic in_ready, scalar_busy, out_valid, out_last, out_sat;
  logic [63:0] in_data = '0, out_data;
  logic [15:0] scalar_in = '0;
  int total = 0, bad = 0;
  typedef struct packed {logic [63:0] d; logic l; logic s;} ob_t;
  typedef struct {logic [15:0] s; logic [63:0] din; logic [63:0] dout; logic sat;} vec_t;
  ob_t got[$];
  ob_t exp_q[$];
  vec_t tbl[6];

  matrix_scalar_mul_stream dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .scalar_we(scalar_we), .scalar_in(scalar_in), .scalar_busy(scalar_busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && out_valid && out_ready) got.push_back(ob_t'({out_data, out_last, out_sat}));

  function automatic logic [63:0] pk(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [63:0] beat(input int k, input int m);
    logic [63:0] r;
    for (int j = 0; j < 4; j++) r[j*16 +: 16] = 16'((k * 16 + j + 1) * m);
    return r;
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, act, want);
    end
  endtask

  task automatic push_exp(input logic [63:0] d, input logic l, input logic s);
    exp_q.push_back(ob_t'({d, l, s}));
  endtask

  task automatic send_beat(input logic [63:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_accept", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic write_scalar(input logic [15:0] v);
    scalar_we = 1'b1;
    scalar_in = v;
    @(negedge clk);
    chk("wr_blocks_in", in_ready, 0);
    @(posedge clk);
    #1;
    scalar_we = 1'b0;
  endtask

  task automatic drain(input string n);
    int w = 0;
    while (got.size() < exp_q.size() && w < 40) begin
      @(posedge clk);
      #1;
      w++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({n, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      chk($sformatf("%s_data%0d", n, i), got[i].d, exp_q[i].d);
      chk($sformatf("%s_last%0d", n, i), got[i].l, exp_q[i].l);
      chk($sformatf("%s_sat%0d", n, i), got[i].s, exp_q[i].s);
    end
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'h0200, pk(16'h0100, 16'h0100, 16'h0100, 16'h0100), pk(16'h0200, 16'h0200, 16'h0200, 16'h0200), 1'b0};
    tbl[1] = '{16'h0180, pk(16'h0001, 16'hFFFF, 16'h0002, 16'h0000), pk(16'h0002, 16'hFFFF, 16'h0003, 16'h0000), 1'b0};
    tbl[2] = '{16'h7FFF, pk(16'h7FFF, 16'h8000, 16'h0001, 16'h0000), pk(16'h7FFF, 16'h8000, 16'h0080, 16'h0000), 1'b1};
    tbl[3] = '{16'hFF00, pk(16'h0100, 16'h8000, 16'h7FFF, 16'hFFFF), pk(16'hFF00, 16'h7FFF, 16'h8001, 16'h0001), 1'b1};
    tbl[4] = '{16'h0080, pk(16'h0003, 16'hFFFD, 16'h0001, 16'hFFFF), pk(16'h0002, 16'hFFFF, 16'h0001, 16'h0000), 1'b0};
    tbl[5] = '{16'h0000, pk(16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF), 64'h0, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_busy", scalar_busy, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    write_scalar(16'h0200);
    in_valid = 1'b1;
    in_data = pk(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    @(negedge clk);
    chk("lat_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("lat_c1_valid", out_valid, 0);
    chk("lat_c1_busy", scalar_busy, 1);
    @(posedge clk);
    #1;
    chk("lat_c2_valid", out_valid, 1);
    chk("lat_c2_data", out_data, pk(16'h0200, 16'h0200, 16'h0200, 16'h0200));
    chk("lat_c2_sat", out_sat, 0);
    chk("lat_c2_last", out_last, 0);
    for (int b = 0; b < 4; b++) push_exp(pk(16'h0200, 16'h0200, 16'h0200, 16'h0200), b == 3, 1'b0);
    for (int b = 0; b < 3; b++) send_beat(pk(16'h0100, 16'h0100, 16'h0100, 16'h0100));
    in_valid = 1'b0;
    drain("basic");
    for (int v = 0; v < 6; v++) begin
      chk($sformatf("vec%0d_idle_busy", v), scalar_busy, 0);
      write_scalar(tbl[v].s);
      for (int b = 0; b < 4; b++) begin
        push_exp(tbl[v].dout, b == 3, tbl[v].sat);
        send_beat(tbl[v].din);
      end
      in_valid = 1'b0;
      drain($sformatf("vec%0d", v));
    end
    write_scalar(16'h0100);
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        chk("lock_busy", scalar_busy, 1);
        scalar_we = 1'b1;
        scalar_in = 16'h0400;
      end
      push_exp(beat(k, 1), k % 4 == 3, 1'b0);
      send_beat(beat(k, 1));
      scalar_we = 1'b0;
    end
    in_data = beat(8, 1);
    scalar_we = 1'b1;
    scalar_in = 16'h0400;
    @(negedge clk);
    chk("wrap_wr_in_ready", in_ready, 0);
    chk("wrap_wr_busy", scalar_busy, 0);
    @(posedge clk);
    #1;
    scalar_we = 1'b0;
    chk("wrap_no_accept", scalar_busy, 0);
    for (int k = 8; k < 12; k++) begin
      push_exp(beat(k, 4), k == 11, 1'b0);
      send_beat(beat(k, 1));
    end
    in_valid = 1'b0;
    drain("frame");
    write_scalar(16'h0100);
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          push_exp(beat(20 + k, 1), k % 4 == 3, 1'b0);
          send_beat(beat(20 + k, 1));
        end
        in_valid = 1'b0;
      end
      begin
        int w = 0;
        logic [63:0] hold;
        while (!out_valid && w < 20) begin
          @(posedge clk);
          #1;
          w++;
        end
        chk("bp_seen", out_valid, 1);
        hold = out_data;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk($sformatf("bp_in_ready%0d", c), in_ready, 0);
          chk($sformatf("bp_valid%0d", c), out_valid, 1);
          chk($sformatf("bp_hold%0d", c), out_data, hold);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("bp");
    write_scalar(16'h0300);
    send_beat(beat(40, 1));
    send_beat(beat(41, 1));
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", scalar_busy, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_rst_flush", got.size(), 0);
    got.delete();
    for (int b = 0; b < 4; b++) begin
      push_exp(64'h0, b == 3, 1'b0);
      send_beat(beat(50 + b, 1));
    end
    in_valid = 1'b0;
    drain("post_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
